// File: rtl/elevator_floor_ctrl.sv
// Elevator car-motion controller: services latched floor calls, times travel and
// door dwell with internal counters, and strobes the k input of each call flip-flop.
module elevator_floor_ctrl #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  call_req,
    output logic [FLOORS-1:0]  call_clr_k,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               busy
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = $clog2(DOOR_CYCLES);
    localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    function automatic logic calls_above(input logic [FLOORS-1:0] calls,
                                         input logic [FLOOR_W-1:0] floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (calls[i] && (i > int'(floor))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic calls_below(input logic [FLOORS-1:0] calls,
                                         input logic [FLOOR_W-1:0] floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (calls[i] && (i < int'(floor))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
        return FLOORS'(1) << floor;
    endfunction

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
    logic [TCW-1:0]     travel_cnt_q, travel_cnt_d;
    logic [DCW-1:0]     door_cnt_q, door_cnt_d;
    logic [FLOORS-1:0]  call_clr_k_q, call_clr_k_d;
    logic               motor_up_q, motor_up_d;
    logic               motor_down_q, motor_down_d;
    logic               door_open_q, door_open_d;
    logic               busy_q, busy_d;

    logic               here, above, below, door_first;
    logic [FLOOR_W-1:0] next_floor;

    assign here  = call_req[cur_floor_q];
    assign above = calls_above(call_req, cur_floor_q);
    assign below = calls_below(call_req, cur_floor_q);
    // A strobe is only ever high in the first cycle after (re)opening the door,
    // when the JK bank has not yet cleared the call, so that cycle ignores 'here'.
    assign door_first = |call_clr_k_q;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_floor_d  = cur_floor_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        call_clr_k_d = '0;
        next_floor   = cur_floor_q;

        case (state_q)
            S_IDLE: begin
                travel_cnt_d = '0;
                door_cnt_d   = '0;
                if (here) begin
                    state_d      = S_DOOR_OPEN;
                    call_clr_k_d = floor_onehot(cur_floor_q);
                end else if (above && below) begin
                    state_d = (dir_q == DIR_UP) ? S_MOVE_UP : S_MOVE_DOWN;
                end else if (above) begin
                    state_d = S_MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (below) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    next_floor   = (state_q == S_MOVE_UP) ? cur_floor_q + 1'b1
                                                          : cur_floor_q - 1'b1;
                    cur_floor_d  = next_floor;
                    if (call_req[next_floor]) begin
                        state_d      = S_DOOR_OPEN;
                        door_cnt_d   = '0;
                        call_clr_k_d = floor_onehot(next_floor);
                    end else if ((state_q == S_MOVE_UP) ? calls_above(call_req, next_floor)
                                                        : calls_below(call_req, next_floor)) begin
                        state_d = state_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            S_DOOR_OPEN: begin
                if (!door_first && here) begin
                    door_cnt_d   = '0;
                    call_clr_k_d = floor_onehot(cur_floor_q);
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = S_IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        motor_up_d   = (state_d == S_MOVE_UP);
        motor_down_d = (state_d == S_MOVE_DOWN);
        door_open_d  = (state_d == S_DOOR_OPEN);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_UP;
            cur_floor_q  <= '0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            call_clr_k_q <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cur_floor_q  <= cur_floor_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            call_clr_k_q <= call_clr_k_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
        end
    end

    assign call_clr_k = call_clr_k_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign cur_floor  = cur_floor_q;
    assign busy       = busy_q;

endmodule

// File: doc/elevator_floor_ctrl.md
Name: elevator_floor_ctrl

Overview:
Car-motion controller for the elevator, one stage upstream of the per-floor JK call-request flip-flops.
- Reads the latched call bits (the q outputs of the JK bank).
- Sequences the car: idle, move up, move down, door open.
- Emits one-cycle clear strobes that drive the k input of each floor's flip-flop, with j=0 and en=1.
- Floor travel and door dwell are timed internally by counters; there are no position sensors.

Parameters:
FLOORS, 4, number of floors; floor 0 is the ground floor.
FLOOR_W, 2, width of the floor index; must satisfy 2^FLOOR_W >= FLOORS.
TRAVEL_CYCLES, 4, clock cycles to move one floor; minimum 1.
DOOR_CYCLES, 8, clock cycles the door stays open; minimum 2.

Ports:
clk  in  1  system clock, rising-edge active.
rst_n  in  1  asynchronous active-low reset.
call_req  in  FLOORS  latched call per floor (JK q outputs); level-sensitive.
call_clr_k  out  FLOORS  one-hot, one-cycle clear pulse to the k input of the serviced floor.
motor_up  out  1  car moving up.
motor_down  out  1  car moving down.
door_open  out  1  door open.
cur_floor  out  FLOOR_W  current floor index.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered (Moore).
- Reset values:
  - state IDLE, cur_floor 0, direction register dir=UP.
  - travel_cnt 0, door_cnt 0.
  - All outputs 0.
- Reset asserted mid-operation aborts immediately to the reset values. No clear strobe is issued. Pending calls remain in the JK bank and are serviced after release.
- Derived terms (combinational from call_req and cur_floor):
  - above = any call_req bit with index > cur_floor.
  - below = any call_req bit with index < cur_floor.
  - here = call_req[cur_floor].
- IDLE, evaluated on each edge in priority order:
  - here -> DOOR_OPEN.
  - else above and below both set -> keep dir and move that way.
  - else above -> MOVE_UP, dir=UP.
  - else below -> MOVE_DOWN, dir=DOWN.
  - else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - motor_up / motor_down high for the whole state.
  - travel_cnt is cleared on entry and increments each cycle.
  - On the edge where travel_cnt == TRAVEL_CYCLES-1: cur_floor steps ±1 and travel_cnt clears.
  - Same edge, decision using the new floor index:
    - call at the new floor -> DOOR_OPEN.
    - else calls remaining in the same direction -> stay in the state.
    - else -> IDLE.
- Floor bounds: cur_floor never exceeds FLOORS-1 or goes below 0. MOVE_UP is never entered at the top floor and MOVE_DOWN never at floor 0.
- DOOR_OPEN:
  - door_open high.
  - door_cnt is cleared on entry.
  - call_clr_k[cur_floor] is high during the first DOOR_OPEN cycle only.
  - Exit to IDLE on the edge where door_cnt == DOOR_CYCLES-1, so door_open is high for exactly DOOR_CYCLES cycles.
- Door hold: if here is sampled high in any DOOR_OPEN cycle after the first (a new press at the current floor), door_cnt restarts at 0 and call_clr_k[cur_floor] pulses again in the next cycle.
- Output invariants:
  - motor_up, motor_down and door_open are mutually exclusive.
  - call_clr_k is at most one-hot and is 0 outside DOOR_OPEN.
- Calls that arrive while moving are picked up at each floor arrival, using the same here / same-direction rules.

Test Plan:
- Reset, then call_req=4'b0100 from cycle 0 -> MOVE_UP entered at edge 1; cur_floor=1 at edge 5 and 2 at edge 9; motor_up high 8 cycles; door_open high edges 9-17; call_clr_k=4'b0100 for cycle 9 only; IDLE at edge 17.
- Car idle at floor 2, call_req=4'b0001 -> MOVE_DOWN for 8 cycles; cur_floor 1 then 0; door opens at floor 0; call_clr_k=4'b0001.
- Car moving up from floor 0 toward floor 3, floor 1 pressed before arrival -> stop at floor 1 with door open for 8 cycles; then IDLE; then continue up to floor 3.
- Car idle at floor 1, dir=UP, call_req=4'b1001 -> goes up first; services floor 3; then returns down to floor 0.
- DOOR_OPEN at floor 2, call_req[2] re-asserted in door cycle 5 -> door_cnt restarts; second call_clr_k pulse; door_open high for 5+8 = 13 cycles in total.
- rst_n pulled low during MOVE_UP at travel_cnt=2 -> all outputs 0 and cur_floor=0 immediately; after release with call_req still set, the call is serviced normally.
